// File: rtl/mod_exp_pkg.sv
// Shared state encoding and parameter defaults for the mod-exp engine scheduler.
package mod_exp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_WAIT_CLR  = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_ABORT     = 3'd4,
    ST_RESP      = 3'd5
  } state_e;

  localparam int DEF_BUS_WIDTH      = 256;
  localparam int DEF_TIMEOUT_CYCLES = 1 << 20;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester after 'last', wrapping; one-hot grant.
// Zero latency; grants nothing while enable is low.
module rr_arbiter
  import mod_exp_pkg::*;
#(
  parameter int N    = 2,
  parameter int ID_W = id_width(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] last,
  input  logic            enable,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] gnt_id
);

  logic            hi_found;
  logic            lo_found;
  logic [ID_W-1:0] hi_id;
  logic [ID_W-1:0] lo_id;

  // Descending scan so the surviving assignment is the lowest matching index.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_id    = '0;
    lo_id    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo_found = 1'b1;
        lo_id    = ID_W'(i);
        if (ID_W'(i) > last) begin
          hi_found = 1'b1;
          hi_id    = ID_W'(i);
        end
      end
    end
  end

  always_comb begin
    gnt_id = hi_found ? hi_id : lo_id;
    gnt    = '0;
    for (int i = 0; i < N; i++) begin
      gnt[i] = enable && lo_found && (gnt_id == ID_W'(i));
    end
  end

endmodule

// File: rtl/mod_exp_scheduler.sv
// Shares one mod-exp engine between NUM_REQ requesters: accept in IDLE, start, ignore stale valid,
// capture result or abort on watchdog, one-cycle response strobe; responses cannot be backpressured.
module mod_exp_scheduler
  import mod_exp_pkg::*;
#(
  parameter int BUS_WIDTH      = DEF_BUS_WIDTH,
  parameter int NUM_REQ        = 2,
  parameter int ID_W           = id_width(NUM_REQ),
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*BUS_WIDTH-1:0] req_m,
  input  logic [NUM_REQ*BUS_WIDTH-1:0] req_e,
  input  logic [NUM_REQ*BUS_WIDTH-1:0] req_n,
  output logic [NUM_REQ-1:0]           rsp_valid,
  output logic [BUS_WIDTH-1:0]         rsp_data,
  output logic                         rsp_err,
  output logic [BUS_WIDTH-1:0]         eng_m,
  output logic [BUS_WIDTH-1:0]         eng_e,
  output logic [BUS_WIDTH-1:0]         eng_n,
  output logic                         eng_start,
  output logic                         eng_abort,
  input  logic [BUS_WIDTH-1:0]         eng_out,
  input  logic                         eng_valid,
  output logic                         busy,
  output logic [ID_W-1:0]              grant_id
);

  localparam int              WD_W    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  state_e                 state_q, state_d;
  logic [ID_W-1:0]        last_grant_q;
  logic [ID_W-1:0]        grant_id_q;
  logic [BUS_WIDTH-1:0]   eng_m_q, eng_e_q, eng_n_q;
  logic [BUS_WIDTH-1:0]   rsp_data_q, rsp_data_d;
  logic                   rsp_err_q, rsp_err_d;
  logic [WD_W-1:0]        wd_q, wd_d, wd_inc;
  logic                   wd_hit;

  logic                   arb_en;
  logic [NUM_REQ-1:0]     arb_gnt;
  logic [ID_W-1:0]        arb_id;
  logic                   accept;
  logic [BUS_WIDTH-1:0]   sel_m, sel_e, sel_n;

  rr_arbiter #(
    .N    (NUM_REQ),
    .ID_W (ID_W)
  ) u_arb (
    .req    (req_valid),
    .last   (last_grant_q),
    .enable (arb_en),
    .gnt    (arb_gnt),
    .gnt_id (arb_id)
  );

  assign accept = |arb_gnt;

  always_comb begin
    sel_m = '0;
    sel_e = '0;
    sel_n = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_gnt[i]) begin
        sel_m = req_m[i*BUS_WIDTH +: BUS_WIDTH];
        sel_e = req_e[i*BUS_WIDTH +: BUS_WIDTH];
        sel_n = req_n[i*BUS_WIDTH +: BUS_WIDTH];
      end
    end
  end

  // Watchdog saturates so a stalled FSM can never see it wrap back below the limit.
  assign wd_hit = (wd_q == WD_LAST);
  assign wd_inc = (wd_q == '1) ? wd_q : wd_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    wd_d       = wd_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    arb_en     = 1'b0;
    eng_start  = 1'b0;
    eng_abort  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        arb_en = 1'b1;
        if (accept) state_d = ST_START;
      end
      ST_START: begin
        eng_start = 1'b1;
        wd_d      = '0;
        state_d   = ST_WAIT_CLR;
      end
      ST_WAIT_CLR: begin
        wd_d = wd_inc;
        if (wd_hit)          state_d = ST_ABORT;
        else if (!eng_valid) state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        wd_d = wd_inc;
        if (wd_hit) begin
          state_d = ST_ABORT;
        end else if (eng_valid) begin
          rsp_data_d = eng_out;
          rsp_err_d  = 1'b0;
          state_d    = ST_RESP;
        end
      end
      ST_ABORT: begin
        eng_abort  = 1'b1;
        rsp_data_d = '0;
        rsp_err_d  = 1'b1;
        state_d    = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      last_grant_q <= ID_W'(NUM_REQ - 1);
      grant_id_q   <= '0;
      eng_m_q      <= '0;
      eng_e_q      <= '0;
      eng_n_q      <= '0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
      wd_q         <= '0;
    end else begin
      state_q    <= state_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      wd_q       <= wd_d;
      if (accept) begin
        last_grant_q <= arb_id;
        grant_id_q   <= arb_id;
        eng_m_q      <= sel_m;
        eng_e_q      <= sel_e;
        eng_n_q      <= sel_n;
      end
    end
  end

  always_comb begin
    rsp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rsp_valid[i] = (state_q == ST_RESP) && (grant_id_q == ID_W'(i));
    end
  end

  assign req_ready = arb_gnt;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign eng_m     = eng_m_q;
  assign eng_e     = eng_e_q;
  assign eng_n     = eng_n_q;
  assign busy      = (state_q != ST_IDLE);
  assign grant_id  = grant_id_q;

endmodule

// File: tb/tb_mod_exp_scheduler.sv
// Bench for mod_exp_scheduler with a behavioural sticky-valid engine stub and a round-robin reference model.
module tb_mod_exp_scheduler;

  localparam int BW  = 256;
  localparam int NR  = 2;
  localparam int IDW = 1;
  localparam int TO  = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset = 1'b1;
  logic [NR-1:0]     req_valid = '0;
  logic [NR-1:0]     req_ready, rsp_valid;
  logic [NR*BW-1:0]  req_m = '0, req_e = '0, req_n = '0;
  logic [BW-1:0]     rsp_data, eng_m, eng_e, eng_n;
  logic [BW-1:0]     eng_out = '0;
  logic              rsp_err, eng_start, eng_abort, busy;
  logic              eng_valid = 1'b0;
  logic [IDW-1:0]    grant_id;

  mod_exp_scheduler #(.BUS_WIDTH(BW), .NUM_REQ(NR), .ID_W(IDW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_m(req_m), .req_e(req_e), .req_n(req_n), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .eng_m(eng_m), .eng_e(eng_e), .eng_n(eng_n),
    .eng_start(eng_start), .eng_abort(eng_abort), .eng_out(eng_out), .eng_valid(eng_valid),
    .busy(busy), .grant_id(grant_id)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int mdl_last = NR - 1;

  function automatic logic [BW-1:0] modexp(input logic [BW-1:0] m, input logic [BW-1:0] e, input logic [BW-1:0] n);
    logic [2*BW-1:0] r, b, nn;
    nn = {{BW{1'b0}}, n};
    r  = 1 % nn;
    b  = {{BW{1'b0}}, m} % nn;
    for (int i = 0; i < BW; i++) begin
      if (e[i]) r = (r * b) % nn;
      b = (b * b) % nn;
    end
    return r[BW-1:0];
  endfunction

  function automatic int pick(input int last, input logic [NR-1:0] rv);
    for (int k = 1; k <= NR; k++) if (rv[(last + k) % NR]) return (last + k) % NR;
    return -1;
  endfunction

  function automatic logic [NR-1:0] onehot(input int i);
    return NR'(1) << i;
  endfunction

  function automatic logic [BW-1:0] slice(input logic [NR*BW-1:0] v, input int i);
    return v[i*BW +: BW];
  endfunction

  // Engine stub: sticky valid, optional stale hold after start, optional never-complete mode.
  int eng_lat = 6, eng_hold = 0;
  bit eng_never = 1'b0;
  int lat_cnt = 0, hold_cnt = 0;
  bit job = 1'b0;
  logic [BW-1:0] job_res = '0;

  always @(posedge clk) begin
    if (reset || eng_abort) begin
      eng_valid <= 1'b0; job <= 1'b0; lat_cnt <= 0; hold_cnt <= 0;
    end else if (eng_start) begin
      job <= 1'b1; lat_cnt <= eng_lat; hold_cnt <= eng_hold;
      job_res <= modexp(eng_m, eng_e, eng_n);
      if (eng_hold == 0) eng_valid <= 1'b0;
    end else begin
      if (hold_cnt > 0) begin
        hold_cnt <= hold_cnt - 1;
        if (hold_cnt == 1) eng_valid <= 1'b0;
      end
      if (job && lat_cnt > 0) begin
        lat_cnt <= lat_cnt - 1;
        if (lat_cnt == 1) begin
          job <= 1'b0;
          if (!eng_never) begin eng_valid <= 1'b1; eng_out <= job_res; end
        end
      end
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic [NR-1:0] vec; logic [BW-1:0] data; logic err; logic [IDW-1:0] gid; } rsp_rec_t;
  int acc_cyc[$], acc_id[$], start_cyc[$], abort_cyc[$], rise_cyc[$];
  logic [BW-1:0] start_m[$], start_e[$], start_n[$];
  rsp_rec_t rsp_q[$];
  int ready_seen[NR];
  int viol = 0;
  bit prev_rst = 1'b1, prev_acc = 1'b0, prev_start = 1'b0, prev_valid = 1'b0;
  logic [3*BW-1:0] prev_ops = '0;

  // Event logger plus continuous protocol watch: one-hot ready only when idle, single start pulse, operand hold.
  always @(negedge clk) begin
    if (!reset) begin
      if (req_ready != '0 && ($countones(req_ready) != 1 || busy)) viol++;
      for (int i = 0; i < NR; i++) if (req_ready[i]) ready_seen[i]++;
      if (|(req_ready & req_valid)) begin
        acc_cyc.push_back(cyc);
        for (int i = 0; i < NR; i++) if (req_ready[i] && req_valid[i]) acc_id.push_back(i);
      end
      if (eng_start) begin
        start_cyc.push_back(cyc); start_m.push_back(eng_m); start_e.push_back(eng_e); start_n.push_back(eng_n);
        if (prev_start) viol++;
      end
      if (eng_abort) abort_cyc.push_back(cyc);
      if (eng_valid && !prev_valid) rise_cyc.push_back(cyc);
      if (rsp_valid != '0) rsp_q.push_back('{cyc, rsp_valid, rsp_data, rsp_err, grant_id});
      if (!prev_acc && !prev_rst && {eng_m, eng_e, eng_n} !== prev_ops) viol++;
    end
    prev_rst   = reset;
    prev_acc   = |(req_ready & req_valid) && !reset;
    prev_start = eng_start && !reset;
    prev_valid = eng_valid;
    prev_ops   = {eng_m, eng_e, eng_n};
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_logs();
    acc_cyc.delete(); acc_id.delete(); start_cyc.delete(); abort_cyc.delete(); rise_cyc.delete();
    start_m.delete(); start_e.delete(); start_n.delete(); rsp_q.delete();
    for (int i = 0; i < NR; i++) ready_seen[i] = 0;
    viol = 0;
  endtask

  task automatic wait_acc(input int n, output bit to);
    int b = 0;
    to = 1'b0;
    while (acc_cyc.size() < n) begin
      tick(); b++;
      if (b > 200) begin to = 1'b1; break; end
    end
  endtask

  task automatic wait_rsp(input int n, output bit to);
    int b = 0;
    to = 1'b0;
    while (rsp_q.size() < n) begin
      tick(); b++;
      if (b > 400) begin to = 1'b1; break; end
    end
  endtask

  task automatic set_ops(input int id, input logic [BW-1:0] m, input logic [BW-1:0] e, input logic [BW-1:0] n);
    req_m[id*BW +: BW] = m; req_e[id*BW +: BW] = e; req_n[id*BW +: BW] = n;
  endtask

  task automatic rand_ops(input int id);
    logic [BW-1:0] m, e, n;
    m = '0; e = '0; n = '0;
    m[63:0] = {$urandom, $urandom};
    e[31:0] = $urandom;
    n[63:0] = {$urandom, $urandom} | 64'h8000_0000_0000_0001;
    set_ops(id, m, e, n);
  endtask

  task automatic do_reset();
    reset = 1'b1; req_valid = '0;
    tick(); tick();
    reset = 1'b0; mdl_last = NR - 1;
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = '0;
    tick(); tick();
    @(negedge clk);
    checks++; if (req_ready !== '0) begin errors++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end
    checks++; if (rsp_valid !== '0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    checks++; if (rsp_data !== '0) begin errors++; $display("FAIL reset_rsp_data: got %0h want 0", rsp_data); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err: got %b want 0", rsp_err); end
    checks++; if ({eng_m, eng_e, eng_n} !== '0) begin errors++; $display("FAIL reset_eng_ops: nonzero operands"); end
    checks++; if (eng_start !== 1'b0) begin errors++; $display("FAIL reset_eng_start: got %b want 0", eng_start); end
    checks++; if (eng_abort !== 1'b0) begin errors++; $display("FAIL reset_eng_abort: got %b want 0", eng_abort); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (grant_id !== '0) begin errors++; $display("FAIL reset_grant_id: got %0d want 0", grant_id); end
    tick();
    reset = 1'b0; mdl_last = NR - 1;
    tick();
  endtask

  task automatic test_single_job();
    bit to;
    int exp;
    clear_logs(); eng_lat = 6; eng_hold = 0; eng_never = 0;
    set_ops(0, BW'(4), BW'(13), BW'(497));
    req_valid = 2'b01;
    exp = pick(mdl_last, req_valid);
    wait_acc(1, to);
    req_valid = '0; mdl_last = exp;
    checks++; if (to) begin errors++; $display("FAIL single_accept: got timeout want accept"); end
    wait_rsp(1, to);
    repeat (3) tick();
    checks++; if (rsp_q.size() != 1 || start_cyc.size() != 1 || acc_id.size() != 1) begin
      errors++; $display("FAIL single_counts: got rsp=%0d start=%0d acc=%0d want 1/1/1", rsp_q.size(), start_cyc.size(), acc_id.size());
    end else begin
      checks++; if (acc_id[0] != exp) begin errors++; $display("FAIL single_grant: got %0d want %0d", acc_id[0], exp); end
      checks++; if (start_cyc[0] != acc_cyc[0] + 1) begin errors++; $display("FAIL single_start_lat: got %0d want %0d", start_cyc[0], acc_cyc[0] + 1); end
      checks++; if (rsp_q[0].vec !== 2'b01) begin errors++; $display("FAIL single_rsp_valid: got %b want 01", rsp_q[0].vec); end
      checks++; if (rsp_q[0].data !== BW'(445)) begin errors++; $display("FAIL single_rsp_data: got %0d want 445", rsp_q[0].data); end
      checks++; if (rsp_q[0].err !== 1'b0) begin errors++; $display("FAIL single_rsp_err: got %b want 0", rsp_q[0].err); end
      checks++; if (rsp_q[0].cyc != start_cyc[0] + eng_lat + 2) begin errors++; $display("FAIL single_rsp_cycle: got %0d want %0d", rsp_q[0].cyc, start_cyc[0] + eng_lat + 2); end
    end
    checks++; if (viol != 0) begin errors++; $display("FAIL single_protocol: got %0d violations want 0", viol); end
  endtask

  task automatic test_round_robin();
    bit to;
    int exp;
    do_reset(); clear_logs(); eng_lat = 4;
    for (int i = 0; i < NR; i++) rand_ops(i);
    req_valid = 2'b11;
    wait_rsp(4, to);
    req_valid = '0;
    repeat (3) tick();
    checks++; if (to || acc_id.size() != 4 || rsp_q.size() != 4 || start_cyc.size() != 4) begin
      errors++; $display("FAIL rr_counts: got acc=%0d rsp=%0d start=%0d want 4", acc_id.size(), rsp_q.size(), start_cyc.size());
    end else begin
      for (int j = 0; j < 4; j++) begin
        exp = pick(mdl_last, 2'b11); mdl_last = exp;
        checks++; if (acc_id[j] != exp) begin errors++; $display("FAIL rr_grant[%0d]: got %0d want %0d", j, acc_id[j], exp); end
        checks++; if (rsp_q[j].vec !== onehot(exp) || rsp_q[j].gid !== IDW'(exp)) begin
          errors++; $display("FAIL rr_rsp_owner[%0d]: got vec=%b gid=%0d want owner %0d", j, rsp_q[j].vec, rsp_q[j].gid, exp);
        end
        checks++; if ({start_m[j], start_e[j], start_n[j]} !== {slice(req_m, exp), slice(req_e, exp), slice(req_n, exp)}) begin
          errors++; $display("FAIL rr_operands[%0d]: got m=%0h want m=%0h", j, start_m[j], slice(req_m, exp));
        end
        checks++; if (rsp_q[j].data !== modexp(slice(req_m, exp), slice(req_e, exp), slice(req_n, exp))) begin
          errors++; $display("FAIL rr_data[%0d]: got %0h want %0h", j, rsp_q[j].data, modexp(slice(req_m, exp), slice(req_e, exp), slice(req_n, exp)));
        end
        if (j > 0) begin
          checks++; if (acc_cyc[j] != rsp_q[j-1].cyc + 1) begin errors++; $display("FAIL rr_gap[%0d]: got %0d want %0d", j, acc_cyc[j], rsp_q[j-1].cyc + 1); end
        end
      end
    end
    checks++; if (viol != 0) begin errors++; $display("FAIL rr_protocol: got %0d violations want 0", viol); end
  endtask

  task automatic test_stale_valid();
    bit to;
    int exp;
    clear_logs(); eng_lat = 10; eng_hold = 3; eng_never = 0;
    rand_ops(1);
    req_valid = 2'b10;
    exp = pick(mdl_last, req_valid);
    wait_acc(1, to);
    req_valid = '0; mdl_last = exp;
    wait_rsp(1, to);
    repeat (10) tick();
    checks++; if (to || rsp_q.size() != 1 || start_cyc.size() != 1 || rise_cyc.size() != 1) begin
      errors++; $display("FAIL stale_counts: got rsp=%0d start=%0d rise=%0d want 1/1/1", rsp_q.size(), start_cyc.size(), rise_cyc.size());
    end else begin
      checks++; if (rsp_q[0].cyc != rise_cyc[0] + 1) begin errors++; $display("FAIL stale_rsp_cycle: got %0d want %0d", rsp_q[0].cyc, rise_cyc[0] + 1); end
      checks++; if (rsp_q[0].cyc != start_cyc[0] + eng_lat + 2) begin errors++; $display("FAIL stale_rsp_latency: got %0d want %0d", rsp_q[0].cyc, start_cyc[0] + eng_lat + 2); end
      checks++; if (rsp_q[0].data !== modexp(slice(req_m, 1), slice(req_e, 1), slice(req_n, 1)) || rsp_q[0].vec !== onehot(exp)) begin
        errors++; $display("FAIL stale_rsp_data: got %0h vec=%b want %0h vec=%b", rsp_q[0].data, rsp_q[0].vec, modexp(slice(req_m, 1), slice(req_e, 1), slice(req_n, 1)), onehot(exp));
      end
    end
    eng_hold = 0;
  endtask

  task automatic test_timeout();
    bit to;
    int exp;
    clear_logs(); eng_lat = 4; eng_never = 1;
    rand_ops(0);
    req_valid = 2'b01;
    exp = pick(mdl_last, req_valid);
    wait_acc(1, to);
    req_valid = '0; mdl_last = exp;
    wait_rsp(1, to);
    tick();
    checks++; if (to || rsp_q.size() != 1 || abort_cyc.size() != 1 || start_cyc.size() != 1) begin
      errors++; $display("FAIL timeout_counts: got rsp=%0d abort=%0d start=%0d want 1/1/1", rsp_q.size(), abort_cyc.size(), start_cyc.size());
    end else begin
      checks++; if (rsp_q[0].cyc != start_cyc[0] + TO + 2) begin errors++; $display("FAIL timeout_rsp_cycle: got %0d want %0d", rsp_q[0].cyc, start_cyc[0] + TO + 2); end
      checks++; if (abort_cyc[0] != rsp_q[0].cyc - 1) begin errors++; $display("FAIL timeout_abort_cycle: got %0d want %0d", abort_cyc[0], rsp_q[0].cyc - 1); end
      checks++; if (rsp_q[0].err !== 1'b1 || rsp_q[0].data !== '0 || rsp_q[0].vec !== onehot(exp)) begin
        errors++; $display("FAIL timeout_rsp: got err=%b data=%0h vec=%b want err=1 data=0 vec=%b", rsp_q[0].err, rsp_q[0].data, rsp_q[0].vec, onehot(exp));
      end
    end
    clear_logs(); eng_never = 0;
    rand_ops(1);
    req_valid = 2'b10;
    exp = pick(mdl_last, req_valid);
    wait_acc(1, to);
    req_valid = '0; mdl_last = exp;
    wait_rsp(1, to);
    checks++; if (to || rsp_q.size() != 1) begin
      errors++; $display("FAIL timeout_recover: got %0d responses want 1", rsp_q.size());
    end else begin
      checks++; if (rsp_q[0].err !== 1'b0 || rsp_q[0].data !== modexp(slice(req_m, 1), slice(req_e, 1), slice(req_n, 1))) begin
        errors++; $display("FAIL timeout_recover_data: got err=%b data=%0h want err=0 data=%0h", rsp_q[0].err, rsp_q[0].data, modexp(slice(req_m, 1), slice(req_e, 1), slice(req_n, 1)));
      end
    end
  endtask

  task automatic test_reset_mid_job();
    bit to;
    clear_logs(); eng_lat = 10;
    rand_ops(1);
    req_valid = 2'b10;
    wait_acc(1, to);
    req_valid = '0;
    repeat (4) tick();
    checks++; if (busy !== 1'b1 || grant_id !== IDW'(1)) begin errors++; $display("FAIL midjob_busy: got busy=%b gid=%0d want 1/1", busy, grant_id); end
    reset = 1'b1;
    tick();
    reset = 1'b0; mdl_last = NR - 1;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || rsp_valid !== '0 || req_ready !== '0 || eng_start !== 1'b0 || eng_abort !== 1'b0) begin
      errors++; $display("FAIL midjob_ctrl: got busy=%b rsp_valid=%b req_ready=%b start=%b abort=%b want all 0", busy, rsp_valid, req_ready, eng_start, eng_abort);
    end
    checks++; if ({eng_m, eng_e, eng_n} !== '0 || rsp_data !== '0 || rsp_err !== 1'b0 || grant_id !== '0) begin
      errors++; $display("FAIL midjob_data: got gid=%0d rsp_data=%0h err=%b want reset values", grant_id, rsp_data, rsp_err);
    end
    repeat (20) tick();
    checks++; if (rsp_q.size() != 0) begin errors++; $display("FAIL midjob_no_rsp: got %0d responses want 0", rsp_q.size()); end
    rand_ops(0);
    req_valid = 2'b11;
    wait_acc(2, to);
    req_valid = '0;
    wait_rsp(1, to);
    checks++; if (to || acc_id.size() != 2 || rsp_q.size() != 1) begin
      errors++; $display("FAIL midjob_regrant_counts: got acc=%0d rsp=%0d want 2/1", acc_id.size(), rsp_q.size());
    end else begin
      checks++; if (acc_id[1] != pick(NR - 1, 2'b11) || rsp_q[0].vec !== onehot(pick(NR - 1, 2'b11))) begin
        errors++; $display("FAIL midjob_regrant: got id=%0d vec=%b want id=%0d", acc_id[1], rsp_q[0].vec, pick(NR - 1, 2'b11));
      end
    end
    mdl_last = pick(NR - 1, 2'b11);
  endtask

  task automatic test_drop_request();
    bit to;
    clear_logs(); eng_lat = 10;
    rand_ops(0); rand_ops(1);
    req_valid = 2'b01;
    wait_acc(1, to);
    req_valid = 2'b10;
    repeat (5) tick();
    req_valid = '0;
    wait_rsp(1, to);
    repeat (6) tick();
    checks++; if (ready_seen[1] != 0) begin errors++; $display("FAIL drop_ready: got %0d ready cycles for req1 want 0", ready_seen[1]); end
    checks++; if (to || acc_id.size() != 1 || rsp_q.size() != 1) begin
      errors++; $display("FAIL drop_counts: got acc=%0d rsp=%0d want 1/1", acc_id.size(), rsp_q.size());
    end else begin
      checks++; if (acc_id[0] != 0 || rsp_q[0].vec !== 2'b01) begin errors++; $display("FAIL drop_owner: got id=%0d vec=%b want 0/01", acc_id[0], rsp_q[0].vec); end
      checks++; if (rsp_q[0].data !== modexp(slice(req_m, 0), slice(req_e, 0), slice(req_n, 0))) begin
        errors++; $display("FAIL drop_data: got %0h want %0h", rsp_q[0].data, modexp(slice(req_m, 0), slice(req_e, 0), slice(req_n, 0)));
      end
    end
    checks++; if (viol != 0) begin errors++; $display("FAIL drop_protocol: got %0d violations want 0", viol); end
  endtask

  initial begin
    test_reset();
    test_single_job();
    test_round_robin();
    test_stale_valid();
    test_timeout();
    test_reset_mid_job();
    test_drop_request();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "time limit");
  end

endmodule
